// File: rtl/ana_scan_seq_pkg.sv
// Shared definitions for the analog scan sequencer: FSM encoding, register map
// and CTRL/STATUS/RESULT bit positions.
package ana_scan_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_CONVERT,
        S_STORE
    } state_t;

    // mux_sel carries a 3-bit channel index, so NCH is limited to 8
    localparam int CH_W = 3;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_MASK   = 4'd1;
    localparam logic [3:0] ADDR_SETTLE = 4'd2;
    localparam logic [3:0] ADDR_STATUS = 4'd3;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_TMO    = 2;
    localparam int STAT_CH_LSB = 4;

    localparam int RES_FRESH   = 15;

endpackage

// File: rtl/ana_scan_seq_next_ch.sv
// Priority search: lowest enabled channel at or above ptr; when none exists,
// wrap is set and idx falls back to the lowest enabled channel overall.
module ana_next_ch
    import ana_scan_seq_pkg::*;
#(
    parameter int NCH = 8,
    parameter int CW  = CH_W
) (
    input  logic [NCH-1:0] mask,
    input  logic [CW:0]    ptr,
    output logic [CW-1:0]  idx,
    output logic           wrap
);

    // Both loops descend so the final assignment is the lowest matching index.
    always_comb begin
        idx  = '0;
        wrap = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) idx = CW'(i);
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && ((CW+1)'(i) >= ptr)) begin
                idx  = CW'(i);
                wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ana_scan_seq.sv
// Analog mux scan sequencer: walks the enabled channels, settles the mux,
// starts the ADC, stores each result and exposes everything on an Avalon slave.
module ana_scan_seq
    import ana_scan_seq_pkg::*;
#(
    parameter int NCH      = 8,
    parameter int SETTLE_W = 16,
    parameter int TMO      = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic [3:0]  mux_sel,
    output logic        adc_start,
    input  logic        adc_done,
    input  logic [11:0] adc_data,
    output logic        irq
);

    localparam int TW = $clog2(TMO + 1);

    state_t               state, state_nx;
    logic                 run, cont, irq_en, done, tmo_flag, mux_en, busy;
    logic [NCH-1:0]       mask, fresh;
    logic [NCH-1:0][11:0] res;
    logic [SETTLE_W-1:0]  settle, scnt;
    logic [TW-1:0]        tcnt;
    logic [CH_W-1:0]      ch, ptr, nx_idx;
    logic [CH_W:0]        srch_ptr;
    logic                 nx_wrap, wr, rd, tmo_hit, settle_end;
    logic [11:0]          conv_data;
    logic [15:0]          rd_mux;

    assign wr         = chipselect & ~write_n;
    assign rd         = chipselect & ~read_n;
    assign busy       = (state != S_IDLE);
    assign mux_sel    = {mux_en, ch};
    assign irq        = irq_en & (done | tmo_flag);
    assign tmo_hit    = (tcnt == TW'(TMO - 1));
    assign settle_end = (scnt <= SETTLE_W'(1));

    // One search unit: SELECT looks from the pointer, STORE looks past the current channel.
    assign srch_ptr = (state == S_STORE) ? ({1'b0, ch} + (CH_W+1)'(1)) : {1'b0, ptr};

    ana_next_ch #(.NCH(NCH), .CW(CH_W)) u_next_ch (
        .mask (mask),
        .ptr  (srch_ptr),
        .idx  (nx_idx),
        .wrap (nx_wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (run && mask != '0) state_nx = S_SELECT;
            S_SELECT:  state_nx = (mask == '0) ? S_IDLE : S_SETTLE;
            S_SETTLE:  if (settle_end) state_nx = S_CONVERT;
            S_CONVERT: if (adc_done || tmo_hit) state_nx = S_STORE;
            S_STORE:   state_nx = (!run || (nx_wrap && !cont)) ? S_IDLE : S_SELECT;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run       <= 1'b0;
            cont      <= 1'b0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            tmo_flag  <= 1'b0;
            mux_en    <= 1'b0;
            adc_start <= 1'b0;
            mask      <= '0;
            fresh     <= '0;
            res       <= '0;
            settle    <= '0;
            scnt      <= '0;
            tcnt      <= '0;
            ch        <= '0;
            ptr       <= '0;
            conv_data <= '0;
        end else begin
            adc_start <= 1'b0;
            // Host clears come first so a same-cycle FSM set or store wins.
            if (rd && address[3]) fresh[address[CH_W-1:0]] <= 1'b0;
            if (wr && address == ADDR_STATUS) begin
                if (writedata[STAT_DONE]) done     <= 1'b0;
                if (writedata[STAT_TMO])  tmo_flag <= 1'b0;
            end

            case (state)
                S_IDLE: if (run && mask == '0) run <= 1'b0;
                S_SELECT: begin
                    if (mask == '0) begin
                        run <= 1'b0;
                    end else begin
                        ch     <= nx_idx;
                        mux_en <= 1'b1;
                        scnt   <= (settle == '0) ? SETTLE_W'(1) : settle;
                    end
                end
                S_SETTLE: begin
                    scnt <= scnt - SETTLE_W'(1);
                    if (settle_end) begin
                        adc_start <= 1'b1;
                        tcnt      <= '0;
                    end
                end
                S_CONVERT: begin
                    if (adc_done) begin
                        conv_data <= adc_data;
                    end else if (tmo_hit) begin
                        conv_data <= 12'hFFF;
                        tmo_flag  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_STORE: begin
                    res[ch]   <= conv_data;
                    fresh[ch] <= 1'b1;
                    ptr       <= (!run || nx_wrap) ? '0 : nx_idx;
                    // A stop request ends the scan without reporting done.
                    if (run && nx_wrap && !cont) begin
                        done <= 1'b1;
                        run  <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (state_nx == S_IDLE) mux_en <= 1'b0;

            if (wr && address == ADDR_CTRL) begin
                run    <= writedata[CTRL_RUN];
                cont   <= writedata[CTRL_CONT];
                irq_en <= writedata[CTRL_IRQ_EN];
            end
            if (wr && address == ADDR_MASK)   mask   <= writedata[NCH-1:0];
            if (wr && address == ADDR_SETTLE) settle <= writedata[SETTLE_W-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        if (address[3]) begin
            rd_mux[11:0]      = res[address[CH_W-1:0]];
            rd_mux[RES_FRESH] = fresh[address[CH_W-1:0]];
        end else begin
            case (address)
                ADDR_CTRL: begin
                    rd_mux[CTRL_RUN]    = run;
                    rd_mux[CTRL_CONT]   = cont;
                    rd_mux[CTRL_IRQ_EN] = irq_en;
                end
                ADDR_MASK:   rd_mux[NCH-1:0]      = mask;
                ADDR_SETTLE: rd_mux[SETTLE_W-1:0] = settle;
                ADDR_STATUS: begin
                    rd_mux[STAT_BUSY]              = busy;
                    rd_mux[STAT_DONE]              = done;
                    rd_mux[STAT_TMO]               = tmo_flag;
                    rd_mux[STAT_CH_LSB +: CH_W]    = ch;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else if (rd)  readdata <= rd_mux;
    end

endmodule

// File: tb/tb_ana_scan_seq.sv
// Directed bench for ana_scan_seq: register map, scan ordering, settle timing,
// timeout, continuous stop, read/store collision and mid-scan reset.
module tb_ana_scan_seq;

    logic        clk;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [3:0]  mux_sel;
    logic        adc_start;
    logic        adc_done;
    logic [11:0] adc_data;
    logic        irq;

    int nvec = 0;
    int nerr = 0;

    ana_scan_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .mux_sel    (mux_sel),
        .adc_start  (adc_start),
        .adc_done   (adc_done),
        .adc_data   (adc_data),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    // Waits for adc_start; reports mux_sel at that point and clocks since mux_sel last changed.
    task automatic wait_start(output logic [3:0] sel, output int dly);
        logic [3:0] prev;
        int since;
        bit seen;
        prev = mux_sel; since = 0; dly = -1; sel = 4'bx; seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (mux_sel !== prev) begin since = 0; prev = mux_sel; end
            else since++;
            if (adc_start === 1'b1) begin sel = mux_sel; dly = since; seen = 1'b1; end
        end
    endtask

    task automatic adc_pulse(input logic [11:0] d);
        @(negedge clk);
        adc_done = 1'b1; adc_data = d;
        @(negedge clk);
        adc_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset_n = 1'b0;
        idle(3);
        nvec++; if ({mux_sel, adc_start, irq} !== 6'b0) begin nerr++; $display("FAIL reset_outs got %b exp 000000", {mux_sel, adc_start, irq}); end
        nvec++; if (readdata !== 16'h0) begin nerr++; $display("FAIL reset_readdata got %h exp 0000", readdata); end
        reset_n = 1'b1;
        idle(1);
        bus_read(4'd3, d);
        nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL reset_status got %h exp 0000", d); end
        bus_read(4'd0, d);
        nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL reset_ctrl got %h exp 0000", d); end
        bus_read(4'd8, d);
        nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL reset_result0 got %h exp 0000", d); end
    endtask

    task automatic test_oneshot();
        logic [15:0] d;
        logic [3:0] sel;
        int dly;
        bus_write(4'd1, 16'h0005);
        bus_write(4'd2, 16'h0003);
        bus_write(4'd0, 16'h0005);
        wait_start(sel, dly);
        nvec++; if (sel !== 4'h8) begin nerr++; $display("FAIL oneshot_sel0 got %h exp 8", sel); end
        nvec++; if (dly != 3) begin nerr++; $display("FAIL oneshot_dly0 got %0d exp 3", dly); end
        adc_pulse(12'h123);
        wait_start(sel, dly);
        nvec++; if (sel !== 4'hA) begin nerr++; $display("FAIL oneshot_sel2 got %h exp a", sel); end
        nvec++; if (dly != 3) begin nerr++; $display("FAIL oneshot_dly2 got %0d exp 3", dly); end
        adc_pulse(12'h456);
        idle(4);
        nvec++; if (mux_sel !== 4'h2) begin nerr++; $display("FAIL oneshot_mux_idle got %h exp 2", mux_sel); end
        bus_read(4'd8, d);
        nvec++; if (d !== 16'h8123) begin nerr++; $display("FAIL oneshot_res0 got %h exp 8123", d); end
        bus_read(4'd10, d);
        nvec++; if (d !== 16'h8456) begin nerr++; $display("FAIL oneshot_res2 got %h exp 8456", d); end
        bus_read(4'd3, d);
        nvec++; if (d !== 16'h0022) begin nerr++; $display("FAIL oneshot_status got %h exp 0022", d); end
        bus_read(4'd0, d);
        nvec++; if (d !== 16'h0004) begin nerr++; $display("FAIL oneshot_ctrl got %h exp 0004", d); end
        nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL oneshot_irq_on got %b exp 1", irq); end
        bus_write(4'd0, 16'h0000);
        idle(1);
        nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL oneshot_irq_off got %b exp 0", irq); end
        bus_read(4'd8, d);
        nvec++; if (d !== 16'h0123) begin nerr++; $display("FAIL oneshot_fresh_clr got %h exp 0123", d); end
        bus_write(4'd3, 16'h0002);
    endtask

    task automatic test_settle0();
        logic [15:0] d;
        logic [3:0] sel;
        int dly;
        bus_write(4'd1, 16'h0080);
        bus_write(4'd2, 16'h0000);
        bus_write(4'd0, 16'h0001);
        wait_start(sel, dly);
        nvec++; if (sel !== 4'hF) begin nerr++; $display("FAIL settle0_sel got %h exp f", sel); end
        nvec++; if (dly != 1) begin nerr++; $display("FAIL settle0_dly got %0d exp 1", dly); end
        adc_pulse(12'h7AB);
        idle(4);
        bus_read(4'd15, d);
        nvec++; if (d !== 16'h87AB) begin nerr++; $display("FAIL settle0_res7 got %h exp 87ab", d); end
        bus_read(4'd3, d);
        nvec++; if (d !== 16'h0072) begin nerr++; $display("FAIL settle0_status got %h exp 0072", d); end
        bus_write(4'd3, 16'h0002);
    endtask

    task automatic test_mask_zero();
        logic [15:0] d;
        bus_write(4'd1, 16'h0000);
        bus_write(4'd0, 16'h0001);
        idle(3);
        bus_read(4'd0, d);
        nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL mask0_ctrl got %h exp 0000", d); end
        bus_read(4'd3, d);
        nvec++; if (d !== 16'h0070) begin nerr++; $display("FAIL mask0_status got %h exp 0070", d); end
    endtask

    task automatic test_timeout();
        logic [15:0] d;
        logic [3:0] sel;
        int dly;
        bus_write(4'd1, 16'h0002);
        bus_write(4'd2, 16'h0001);
        bus_write(4'd0, 16'h0001);
        wait_start(sel, dly);
        nvec++; if (sel !== 4'h9) begin nerr++; $display("FAIL tmo_sel got %h exp 9", sel); end
        idle(500);
        bus_read(4'd3, d);
        nvec++; if (d !== 16'h0011) begin nerr++; $display("FAIL tmo_early_status got %h exp 0011", d); end
        idle(600);
        bus_read(4'd3, d);
        nvec++; if (d !== 16'h0016) begin nerr++; $display("FAIL tmo_status got %h exp 0016", d); end
        bus_read(4'd9, d);
        nvec++; if (d !== 16'h8FFF) begin nerr++; $display("FAIL tmo_res1 got %h exp 8fff", d); end
        bus_write(4'd3, 16'h0004);
        bus_read(4'd3, d);
        nvec++; if (d !== 16'h0012) begin nerr++; $display("FAIL tmo_w1c got %h exp 0012", d); end
        bus_write(4'd3, 16'h0002);
    endtask

    task automatic test_continuous();
        logic [15:0] d;
        logic [3:0] sel;
        logic [3:0] exp_sel [4];
        int dly;
        exp_sel = '{4'h8, 4'hF, 4'h8, 4'hF};
        bus_write(4'd1, 16'h0081);
        bus_write(4'd2, 16'h0001);
        bus_write(4'd0, 16'h0003);
        for (int k = 0; k < 4; k++) begin
            wait_start(sel, dly);
            nvec++; if (sel !== exp_sel[k]) begin nerr++; $display("FAIL cont_sel%0d got %h exp %h", k, sel, exp_sel[k]); end
            if (k == 3) bus_write(4'd0, 16'h0002);
            adc_pulse(12'(16 * k + 5));
        end
        idle(4);
        nvec++; if (mux_sel !== 4'h7) begin nerr++; $display("FAIL cont_mux_idle got %h exp 7", mux_sel); end
        bus_read(4'd3, d);
        nvec++; if (d !== 16'h0070) begin nerr++; $display("FAIL cont_status got %h exp 0070", d); end
        bus_read(4'd15, d);
        nvec++; if (d !== 16'h8035) begin nerr++; $display("FAIL cont_res7 got %h exp 8035", d); end
    endtask

    task automatic test_store_read();
        logic [15:0] d;
        logic [3:0] sel;
        int dly;
        bus_write(4'd1, 16'h0008);
        bus_write(4'd0, 16'h0001);
        wait_start(sel, dly);
        nvec++; if (sel !== 4'hB) begin nerr++; $display("FAIL sr_sel got %h exp b", sel); end
        @(negedge clk);
        adc_done = 1'b1; adc_data = 12'h3C3;
        @(negedge clk);
        adc_done = 1'b0; chipselect = 1'b1; read_n = 1'b0; address = 4'd11;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        nvec++; if (readdata !== 16'h0000) begin nerr++; $display("FAIL sr_collide_read got %h exp 0000", readdata); end
        bus_read(4'd11, d);
        nvec++; if (d !== 16'h83C3) begin nerr++; $display("FAIL sr_fresh_kept got %h exp 83c3", d); end
        bus_read(4'd11, d);
        nvec++; if (d !== 16'h03C3) begin nerr++; $display("FAIL sr_fresh_clr got %h exp 03c3", d); end
        bus_write(4'd3, 16'h0002);
    endtask

    task automatic test_reset_midscan();
        logic [15:0] d;
        bus_write(4'd1, 16'h0001);
        bus_write(4'd2, 16'd20);
        bus_write(4'd0, 16'h0005);
        idle(5);
        nvec++; if ({mux_sel, adc_start} !== 5'b10000) begin nerr++; $display("FAIL rst_pre got %b exp 10000", {mux_sel, adc_start}); end
        reset_n = 1'b0;
        #1;
        nvec++; if ({mux_sel, adc_start, irq} !== 6'b0) begin nerr++; $display("FAIL rst_outs got %b exp 000000", {mux_sel, adc_start, irq}); end
        nvec++; if (readdata !== 16'h0) begin nerr++; $display("FAIL rst_readdata got %h exp 0000", readdata); end
        idle(2);
        reset_n = 1'b1;
        adc_pulse(12'hABC);
        idle(3);
        nvec++; if ({mux_sel, adc_start, irq} !== 6'b0) begin nerr++; $display("FAIL rst_post_outs got %b exp 000000", {mux_sel, adc_start, irq}); end
        bus_read(4'd3, d);
        nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL rst_status got %h exp 0000", d); end
        bus_read(4'd8, d);
        nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL rst_res0 got %h exp 0000", d); end
        bus_read(4'd11, d);
        nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL rst_res3 got %h exp 0000", d); end
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        writedata = '0; adc_done = 1'b0; adc_data = '0;
        test_reset();
        test_oneshot();
        test_settle0();
        test_mask_zero();
        test_timeout();
        test_continuous();
        test_store_read();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d vectors", nvec);
        $fatal(1, "watchdog");
    end

endmodule
